breath_ctrl: RTL and testbench



---
 rtl/breath_ctrl_if.sv | 20 ++
 rtl/breath_ctrl.sv | 174 +++++++++++++++++
 tb/tb_breath_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/breath_ctrl_if.sv
// Control and duty/period bus between the breathing controller and its user.
interface breath_ctrl_if;
    logic        en;
    logic        mode;
    logic        trig;
    logic [7:0]  duty;
    logic [31:0] period;
    logic        busy;
    logic        cycle_done;

    modport master (
        output en, mode, trig,
        input  duty, period, busy, cycle_done
    );

    modport slave (
        input  en, mode, trig,
        output duty, period, busy, cycle_done
    );
endinterface

// File: rtl/breath_ctrl.sv
// LED breathing controller: ramps a duty word up/hold/down/hold on a prescaled tick.
// Optional GAMMA_EN macro squares the linear level before it reaches the duty output.
module breath_ctrl #(
    parameter int unsigned PERIOD      = 255,
    parameter int unsigned STEP_CYCLES = 50000,
    parameter int unsigned STEP        = 1,
    parameter int unsigned DUTY_MIN    = 0,
    parameter int unsigned DUTY_MAX    = 255,
    parameter int unsigned HOLD_STEPS  = 16
) (
    input logic          clk,
    input logic          rst,
    breath_ctrl_if.slave bus
);
    localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS == 0) ? 0 : HOLD_STEPS - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [7:0]    LIN_MIN   = 8'(DUTY_MIN);
    localparam logic [7:0]    LIN_MAX   = 8'(DUTY_MAX);
    localparam logic [7:0]    STEP8     = 8'(STEP);
    localparam logic [8:0]    STEP9     = 9'(STEP);
    localparam logic [8:0]    MAX9      = 9'(DUTY_MAX);
    localparam logic [8:0]    FLOOR9    = 9'(DUTY_MIN + STEP);
    localparam bit            NO_HOLD   = (HOLD_STEPS == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_HOLD_HI,
        S_FALL,
        S_HOLD_LO
    } state_t;

    state_t          state;
    logic [7:0]      lin;
    logic [PW-1:0]   prescaler;
    logic [HW-1:0]   hold_cnt;

    logic            tick;
    logic [8:0]      rise_sum;
    logic            rise_top;
    logic            fall_bot;
    logic            hold_end;
    logic            breath_end;

    // Level-to-duty mapping; the squared curve looks linear to the eye.
    function automatic logic [7:0] map_lin(input logic [7:0] x);
`ifdef GAMMA_EN
        logic [15:0] sq;
        sq = 16'(x) * 16'(x) + 16'd255;
        return sq[15:8];
`else
        return x;
`endif
    endfunction

    assign tick     = (prescaler == PRE_LAST);
    assign rise_sum = {1'b0, lin} + STEP9;
    assign rise_top = (rise_sum >= MAX9);
    assign fall_bot = ({1'b0, lin} <= FLOOR9);
    assign hold_end = (hold_cnt == HOLD_LAST);

    // Last tick of a breath: bottom of FALL without hold, or end of the low hold.
    assign breath_end = tick &&
                        (((state == S_FALL) && fall_bot && NO_HOLD) ||
                         ((state == S_HOLD_LO) && hold_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lin        <= LIN_MIN;
            prescaler  <= '0;
            hold_cnt   <= '0;
            bus.duty       <= map_lin(LIN_MIN);
            bus.period     <= 32'(PERIOD);
            bus.busy       <= 1'b0;
            bus.cycle_done <= 1'b0;
        end else begin
            bus.duty       <= map_lin(lin);
            bus.period     <= 32'(PERIOD);
            bus.cycle_done <= 1'b0;

            if (!bus.en) begin
                // Disable wins over everything, including a pending tick.
                state     <= S_IDLE;
                lin       <= LIN_MIN;
                prescaler <= '0;
                hold_cnt  <= '0;
                bus.busy  <= 1'b0;
            end else begin
                if (state != S_IDLE) begin
                    prescaler <= tick ? '0 : prescaler + PRE_ONE;
                end

                case (state)
                    S_IDLE: begin
                        lin <= LIN_MIN;
                        if (!bus.mode || bus.trig) begin
                            state     <= S_RISE;
                            prescaler <= '0;
                            bus.busy  <= 1'b1;
                        end
                    end

                    S_RISE: begin
                        if (tick) begin
                            if (rise_top) begin
                                lin   <= LIN_MAX;
                                state <= NO_HOLD ? S_FALL : S_HOLD_HI;
                            end else begin
                                lin <= rise_sum[7:0];
                            end
                        end
                    end

                    S_HOLD_HI: begin
                        if (tick) begin
                            if (hold_end) begin
                                hold_cnt <= '0;
                                state    <= S_FALL;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_ONE;
                            end
                        end
                    end

                    S_FALL: begin
                        if (tick) begin
                            if (fall_bot) begin
                                lin <= LIN_MIN;
                                if (!NO_HOLD) begin
                                    state <= S_HOLD_LO;
                                end
                            end else begin
                                lin <= lin - STEP8;
                            end
                        end
                    end

                    S_HOLD_LO: begin
                        if (tick) begin
                            if (hold_end) begin
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_ONE;
                            end
                        end
                    end

                    default: begin
                        state    <= S_IDLE;
                        lin      <= LIN_MIN;
                        bus.busy <= 1'b0;
                    end
                endcase

                // Mode is re-sampled here so a mid-breath change lands at the boundary.
                if (breath_end) begin
                    bus.cycle_done <= 1'b1;
                    if (bus.mode) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state    <= S_RISE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_breath_ctrl.sv
// Scoreboard bench for breath_ctrl: expected duty/busy/done per clock queued up front.
module tb_breath_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    breath_ctrl_if bm ();
    breath_ctrl_if bs ();

    breath_ctrl #(
        .PERIOD(255), .STEP_CYCLES(4), .STEP(64),
        .DUTY_MIN(0), .DUTY_MAX(255), .HOLD_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bm)
    );

    breath_ctrl #(
        .PERIOD(255), .STEP_CYCLES(4), .STEP(100),
        .DUTY_MIN(0), .DUTY_MAX(250), .HOLD_STEPS(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .bus(bs)
    );

    typedef struct {
        logic [7:0] duty;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Linear level after each ramp tick, taken from the ramp description.
    int lv_main[12] = '{0, 64, 128, 192, 255, 255, 255, 191, 127, 63, 0, 0};
    int lv_sat[10]  = '{0, 100, 200, 250, 250, 250, 150, 50, 0, 0};

    function automatic logic [7:0] gmap(input int x);
`ifdef GAMMA_EN
        return 8'((x * x + 255) >> 8);
`else
        return 8'(x);
`endif
    endfunction

    // Sample n is taken just after the n-th rising edge since the breath started.
    function automatic void push_breath(input bit sat, input bit cont, input int count);
        int   t;
        int   l;
        int   idx;
        int   lv;
        exp_t e;
        t = sat ? 10 : 12;
        l = 4 * t;
        for (int n = 0; n < count; n++) begin
            idx = (n == 0) ? 0 : ((n - 1) / 4) % t;
            lv  = sat ? lv_sat[idx] : lv_main[idx];
            if (cont) begin
                e.duty = gmap(lv);
                e.busy = 1'b1;
                e.done = (n > 0) && (n % l == 0);
            end else if (n < l) begin
                e.duty = gmap(lv);
                e.busy = 1'b1;
                e.done = 1'b0;
            end else begin
                e.duty = gmap(0);
                e.busy = 1'b0;
                e.done = (n == l);
            end
            sb.push_back(e);
        end
    endfunction

    function automatic void push_one(input logic [7:0] d, input logic b, input logic dn);
        exp_t e;
        e.duty = d;
        e.busy = b;
        e.done = dn;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        bm.en = 1'b0; bm.mode = 1'b0; bm.trig = 1'b0;
        bs.en = 1'b0; bs.mode = 1'b0; bs.trig = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bm.duty !== 8'd0 || bm.period !== 32'd255 || bm.busy !== 1'b0 || bm.cycle_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_main: duty=%0d period=%0d busy=%0b done=%0b, expected 0/255/0/0",
                     bm.duty, bm.period, bm.busy, bm.cycle_done);
        end
        checks++;
        if (bs.duty !== 8'd0 || bs.period !== 32'd255 || bs.busy !== 1'b0 || bs.cycle_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat: duty=%0d period=%0d busy=%0b done=%0b, expected 0/255/0/0",
                     bs.duty, bs.period, bs.busy, bs.cycle_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (bm.duty !== 8'd0 || bm.period !== 32'd255 || bm.busy !== 1'b0 || bm.cycle_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_static cyc %0d: duty=%0d period=%0d busy=%0b done=%0b, expected 0/255/0/0",
                         i, bm.duty, bm.period, bm.busy, bm.cycle_done);
            end
        end
    endtask

    task automatic test_continuous();
        exp_t e;
        int   n;
        bm.mode = 1'b0;
        bm.en   = 1'b1;
        push_breath(1'b0, 1'b1, 2 * 48 + 8);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bm.duty !== e.duty || bm.busy !== e.busy || bm.cycle_done !== e.done || bm.period !== 32'd255) begin
                errors++;
                $display("FAIL continuous n=%0d: duty=%0d busy=%0b done=%0b period=%0d, expected duty=%0d busy=%0b done=%0b period=255",
                         n, bm.duty, bm.busy, bm.cycle_done, bm.period, e.duty, e.busy, e.done);
            end
            n++;
        end
        bm.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_shot();
        exp_t e;
        int   n;
        bm.mode = 1'b1;
        bm.en   = 1'b1;
        bm.trig = 1'b1;
        push_breath(1'b0, 1'b0, 60);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bm.duty !== e.duty || bm.busy !== e.busy || bm.cycle_done !== e.done) begin
                errors++;
                $display("FAIL single_shot n=%0d: duty=%0d busy=%0b done=%0b, expected duty=%0d busy=%0b done=%0b",
                         n, bm.duty, bm.busy, bm.cycle_done, e.duty, e.busy, e.done);
            end
            if (n == 0)  bm.trig = 1'b0;
            if (n == 10) bm.trig = 1'b1;
            if (n == 11) bm.trig = 1'b0;
            n++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        bm.mode = 1'b1;
        bm.en   = 1'b1;
        bm.trig = 1'b1;
        push_breath(1'b0, 1'b0, 49);
        push_breath(1'b0, 1'b0, 49);
        push_one(8'd0, 1'b0, 1'b0);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bm.duty !== e.duty || bm.busy !== e.busy || bm.cycle_done !== e.done) begin
                errors++;
                $display("FAIL back_to_back n=%0d: duty=%0d busy=%0b done=%0b, expected duty=%0d busy=%0b done=%0b",
                         n, bm.duty, bm.busy, bm.cycle_done, e.duty, e.busy, e.done);
            end
            if (n == 49) bm.trig = 1'b0;
            n++;
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   n;
        bm.mode = 1'b0;
        bm.en   = 1'b1;
        bm.trig = 1'b0;
        push_breath(1'b0, 1'b1, 14);
        push_one(gmap(192), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) push_one(gmap(0), 1'b0, 1'b0);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bm.duty !== e.duty || bm.busy !== e.busy || bm.cycle_done !== e.done) begin
                errors++;
                $display("FAIL abort n=%0d: duty=%0d busy=%0b done=%0b, expected duty=%0d busy=%0b done=%0b",
                         n, bm.duty, bm.busy, bm.cycle_done, e.duty, e.busy, e.done);
            end
            if (n == 13) bm.en = 1'b0;
            n++;
        end
        bm.en = 1'b1;
        push_breath(1'b0, 1'b1, 30);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bm.duty !== e.duty || bm.busy !== e.busy || bm.cycle_done !== e.done) begin
                errors++;
                $display("FAIL abort_restart n=%0d: duty=%0d busy=%0b done=%0b, expected duty=%0d busy=%0b done=%0b",
                         n, bm.duty, bm.busy, bm.cycle_done, e.duty, e.busy, e.done);
            end
            n++;
        end
        bm.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturation();
        exp_t e;
        int   n;
        bs.mode = 1'b0;
        bs.trig = 1'b0;
        bs.en   = 1'b1;
        push_breath(1'b1, 1'b1, 90);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (bs.duty !== e.duty || bs.busy !== e.busy || bs.cycle_done !== e.done) begin
                errors++;
                $display("FAIL saturation n=%0d: duty=%0d busy=%0b done=%0b, expected duty=%0d busy=%0b done=%0b",
                         n, bs.duty, bs.busy, bs.cycle_done, e.duty, e.busy, e.done);
            end
            n++;
        end
        bs.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_single_shot();
        test_back_to_back();
        test_abort();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
